// File: rtl/sw_alu_hist.sv
// sw_alu_hist: switch ALU with a circular history of results, shown on two 7-segment digits and LEDs.
// Build option: define ACC_SAT_EN so that accumulate mode saturates instead of wrapping.
module sw_alu_hist #(
   parameter  int DATA_W     = 4,
   parameter  int HIST_DEPTH = 4,
   localparam int VIEW_W     = $clog2(HIST_DEPTH)
) (
   input  logic              clk_50MHZ,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   input  logic [1:0]        mode_i,
   input  logic              strobe_n_i,
   input  logic              clr_n_i,
   input  logic [VIEW_W-1:0] view_i,
   output logic [6:0]        hex1_o,
   output logic [6:0]        hex2_o,
   output logic [7:0]        led_o
);

   typedef enum logic [1:0] {
      MODE_ADD = 2'd0,
      MODE_SUB = 2'd1,
      MODE_AND = 2'd2,
      MODE_ACC = 2'd3
   } mode_t;

   localparam logic [VIEW_W:0] C_FULL = (VIEW_W+1)'(HIST_DEPTH);

   function automatic logic [6:0] f_seg(input logic [3:0] i_nib);
      logic [6:0] w_seg;
      case (i_nib)
         4'h0: w_seg = 7'h40;  4'h1: w_seg = 7'h79;  4'h2: w_seg = 7'h24;  4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;  4'h5: w_seg = 7'h12;  4'h6: w_seg = 7'h02;  4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;  4'h9: w_seg = 7'h10;  4'hA: w_seg = 7'h08;  4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;  4'hD: w_seg = 7'h21;  4'hE: w_seg = 7'h06;  default: w_seg = 7'h0E;
      endcase
      return w_seg;
   endfunction

   // Button synchronizers and falling-edge detectors
   logic       r_strb_s1, r_strb_s2, r_strb_prev, r_strb_pulse;
   logic       r_clr_s1, r_clr_s2, r_clr_prev, r_clr_pulse;
   logic [1:0] r_vld;

   // r_vld marks when s2 holds a genuine sample rather than the reset value, so a
   // button held low across reset release is never mistaken for a fresh press.
   always_ff @(posedge clk_50MHZ) begin
      if (rst_i) begin
         r_vld        <= '0;
         r_strb_s1    <= 1'b1;
         r_strb_s2    <= 1'b1;
         r_strb_prev  <= 1'b0;
         r_strb_pulse <= 1'b0;
         r_clr_s1     <= 1'b1;
         r_clr_s2     <= 1'b1;
         r_clr_prev   <= 1'b0;
         r_clr_pulse  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let each stage see the previous value of the one before it.
         r_vld        <= {r_vld[0], 1'b1};
         r_strb_s1    <= strobe_n_i;
         r_strb_s2    <= r_strb_s1;
         r_strb_prev  <= r_vld[1] & r_strb_s2;
         r_strb_pulse <= r_strb_prev & ~r_strb_s2;
         r_clr_s1     <= clr_n_i;
         r_clr_s2     <= r_clr_s1;
         r_clr_prev   <= r_vld[1] & r_clr_s2;
         r_clr_pulse  <= r_clr_prev & ~r_clr_s2;
      end
   end

   // ALU
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W:0]   w_sum_ab, w_sum_acc;
   logic [DATA_W-1:0] w_res;
   logic              w_flag;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_res     = '0;
      w_flag    = 1'b0;
      w_sum_ab  = {1'b0, op_a_i} + {1'b0, op_b_i};
      w_sum_acc = {1'b0, r_acc} + {1'b0, op_a_i};
      unique case (mode_t'(mode_i))
         MODE_ADD: begin
            w_res  = w_sum_ab[DATA_W-1:0];
            w_flag = w_sum_ab[DATA_W];
         end
         MODE_SUB: begin
            w_res  = op_a_i - op_b_i;
            w_flag = (op_a_i < op_b_i);
         end
         MODE_AND: begin
            w_res  = op_a_i & op_b_i;
            w_flag = ((op_a_i & op_b_i) == '0);
         end
         MODE_ACC: begin
`ifdef ACC_SAT_EN
            w_res  = w_sum_acc[DATA_W] ? '1 : w_sum_acc[DATA_W-1:0];
`else
            w_res  = w_sum_acc[DATA_W-1:0];
`endif
            w_flag = w_sum_acc[DATA_W];
         end
      endcase
   end

   // History bookkeeping; a clear pulse beats a simultaneous strobe pulse
   logic [VIEW_W-1:0] r_wr_ptr;
   logic [VIEW_W:0]   r_count;
   logic [DATA_W:0]   r_hist [HIST_DEPTH];
   logic              w_push;

   assign w_push = r_strb_pulse & ~r_clr_pulse;

   always_ff @(posedge clk_50MHZ) begin
      if (rst_i || r_clr_pulse) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_acc    <= '0;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + VIEW_W'(1);
         if (r_count != C_FULL) r_count <= r_count + (VIEW_W+1)'(1);
         if (mode_t'(mode_i) == MODE_ACC) r_acc <= w_res;
      end
   end

   // NOTE: the history array has no reset; entries beyond r_count are never displayed.
   always_ff @(posedge clk_50MHZ) begin
      if (w_push) r_hist[r_wr_ptr] <= {w_flag, w_res};
   end

   // Display selection, registered
   logic [VIEW_W-1:0] w_rd_idx;
   logic [DATA_W:0]   w_rd;
   logic [7:0]        w_res8;
   logic              w_blank;

   assign w_rd_idx = r_wr_ptr - VIEW_W'(1) - view_i;
   assign w_rd     = r_hist[w_rd_idx];
   assign w_res8   = 8'(w_rd[DATA_W-1:0]);
   assign w_blank  = ({1'b0, view_i} >= r_count);

   always_ff @(posedge clk_50MHZ) begin
      if (rst_i) begin
         hex1_o <= 7'h7F;
         hex2_o <= 7'h7F;
         led_o  <= 8'h04;
      end else begin
         hex1_o <= w_blank ? 7'h7F : f_seg(w_res8[3:0]);
         hex2_o <= w_blank ? 7'h7F : f_seg(w_res8[7:4]);
         led_o  <= {5'(r_count), (r_count == '0), (r_count == C_FULL), ~w_blank & w_rd[DATA_W]};
      end
   end

endmodule

// File: tb/tb_sw_alu_hist.sv
// Directed self-checking bench for sw_alu_hist with DATA_W=4, HIST_DEPTH=4.
module tb_sw_alu_hist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] op_a = '0, op_b = '0;
   logic [1:0] mode = '0;
   logic       strobe_n = 1'b0;
   logic       clr_n = 1'b1;
   logic [1:0] view = '0;
   logic [6:0] hex1, hex2;
   logic [7:0] led;

   int n_checks = 0;
   int n_errors = 0;

   always #10 clk = ~clk;

   sw_alu_hist #(.DATA_W(4), .HIST_DEPTH(4)) dut (
      .clk_50MHZ (clk),
      .rst_i     (rst),
      .op_a_i    (op_a),
      .op_b_i    (op_b),
      .mode_i    (mode),
      .strobe_n_i(strobe_n),
      .clr_n_i   (clr_n),
      .view_i    (view),
      .hex1_o    (hex1),
      .hex2_o    (hex2),
      .led_o     (led)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
      @(negedge clk);
      op_a = a; op_b = b; mode = m; strobe_n = 1'b0;
      repeat (2) @(negedge clk);
      strobe_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic clear(input logic with_strobe);
      @(negedge clk);
      clr_n = 1'b0;
      if (with_strobe) strobe_n = 1'b0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      strobe_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic set_view(input logic [1:0] v);
      @(negedge clk);
      view = v;
      @(negedge clk);
   endtask

   initial begin
      // Reset with the strobe button held low across release
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("reset_hex1", hex1, 7'h7F);
      check("reset_hex2", hex2, 7'h7F);
      check("reset_led", led, 8'h04);
      strobe_n = 1'b1;
      repeat (4) @(negedge clk);
      check("held_strobe_no_push", led, 8'h04);

      // Add with carry, exact latency: sampled edge k, outputs new at k+4
      @(negedge clk);
      op_a = 4'd9; op_b = 4'd8; mode = 2'd0; strobe_n = 1'b0;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 check("add_not_yet_k3", led, 8'h04);
      @(posedge clk);
      #1;
      check("add_hex1", hex1, 7'h79);
      check("add_hex2", hex2, 7'h40);
      check("add_led", led, 8'b0000_1001);
      @(negedge clk);
      strobe_n = 1'b1;
      repeat (3) @(negedge clk);
      set_view(2'd1);
      check("view_past_count_hex1", hex1, 7'h7F);
      check("view_past_count_led", led, 8'b0000_1000);
      set_view(2'd0);

      // Wrap-around: five subtract pushes into four entries
      clear(1'b0);
      check("clear_led", led, 8'h04);
      for (int i = 1; i <= 5; i++) push(4'(i), 4'd0, 2'd1);
      check("wrap_led_v0", led, 8'b0010_0010);
      check("wrap_hex1_v0", hex1, 7'h12);
      set_view(2'd3);
      check("wrap_hex1_v3", hex1, 7'h24);
      check("wrap_hex2_v3", hex2, 7'h40);
      set_view(2'd1);
      check("wrap_hex1_v1", hex1, 7'h19);
      set_view(2'd0);

      // Subtract with borrow, then AND giving zero
      clear(1'b0);
      push(4'd3, 4'd5, 2'd1);
      check("sub_hex1", hex1, 7'h06);
      check("sub_led", led, 8'b0000_1001);
      push(4'd5, 4'd2, 2'd2);
      check("and_hex1", hex1, 7'h40);
      check("and_led", led, 8'b0001_0001);
      set_view(2'd1);
      check("and_hist_v1", hex1, 7'h06);
      set_view(2'd0);

      // Accumulate 15 twice from clear
      clear(1'b0);
      push(4'd15, 4'd0, 2'd3);
      check("acc1_hex1", hex1, 7'h0E);
      check("acc1_led", led, 8'b0000_1000);
      push(4'd15, 4'd0, 2'd3);
`ifdef ACC_SAT_EN
      check("acc2_hex1", hex1, 7'h0E);
`else
      check("acc2_hex1", hex1, 7'h06);
`endif
      check("acc2_led", led, 8'b0001_0001);

      // Clear and strobe pulses in the same cycle: clear wins
      mode = 2'd0;
      clear(1'b1);
      check("collide_led", led, 8'h04);
      check("collide_hex1", hex1, 7'h7F);
      check("collide_hex2", hex2, 7'h7F);
      push(4'd3, 4'd0, 2'd3);
      check("acc_after_clear_hex1", hex1, 7'h30);
      check("acc_after_clear_led", led, 8'b0000_1000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sw_alu_hist.md
# sw_alu_hist

Parametrised successor to the lab2 switch/key ALU. It takes two switch operands and a 2-bit mode, and computes one result per falling edge of a raw push-button strobe. Each result goes into a circular history buffer of the last HIST_DEPTH results. The history entry selected by a view index is driven onto two active-low 7-segment digits and a status LED bus. The block sits between the board I/O (switches, keys) and the HEX/LED pins of the top level.

## Interface
- DATA_W, 4, operand/result width; legal 4..8.
- HIST_DEPTH, 4, history entries; power of two, 2..16.
- VIEW_W, $clog2(HIST_DEPTH), width of view index (derived, not overridden).
- clk_50MHZ  input  1  system clock; the only clock.
- rst_i  input  1  reset; synchronous and active-high.
- op_a_i  input  DATA_W  operand A (switches), asynchronous to clock.
- op_b_i  input  DATA_W  operand B (switches), asynchronous to clock.
- mode_i  input  2  operation: 0 add, 1 sub, 2 and, 3 accumulate.
- strobe_n_i  input  1  raw active-low compute button.
- clr_n_i  input  1  raw active-low clear button.
- view_i  input  VIEW_W  history age to display; 0 = newest.
- hex1_o  output  7  low nibble of the displayed result, segments {g,f,e,d,c,b,a}, active-low.
- hex2_o  output  7  high nibble of the displayed result (zero-extended to 8 bits), same encoding.
- led_o  output  8  [0] flag of the displayed entry, [1] full, [2] empty, [7:3] count (zero-extended).

## Operation
- strobe_n_i and clr_n_i each pass through a 2-FF synchronizer followed by a falling-edge detector. A falling edge produces a 1-cycle pulse. There is no debounce.
- op_a_i, op_b_i and mode_i are sampled in the cycle of the strobe pulse.
- Result and flag by mode:
  - add: {flag,res} = a+b (flag is the carry).
  - sub: res = (a-b) mod 2^DATA_W; flag = (a<b).
  - and: res = a&b; flag = (res==0).
  - accumulate: acc_new = acc+a; res = acc_new; flag = 1 on overflow. acc holds the updated value.
- Only the accumulate mode reads or writes acc.
- Push rules:
  - Each strobe pulse writes {flag,res} at the write pointer, then increments the pointer mod HIST_DEPTH.
  - count saturates at HIST_DEPTH.
  - When the buffer is full, a push overwrites the oldest entry (wrap-around). Pushes are never refused.
- Display selection:
  - The entry shown is the one at (wr_ptr-1-view_i) mod HIST_DEPTH.
  - If view_i >= count, both digits are blank (7'h7F) and led_o[0] = 0.
- Clear pulse: count, wr_ptr and acc go to 0. Stored entries become unreachable.
- Simultaneous clear and strobe pulses in the same cycle: clear wins and no push occurs.
- full = (count==HIST_DEPTH); empty = (count==0).
- Hex digit codes 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, active-low).

## Timing
- A raw strobe falling edge sampled at clock edge k produces a pulse at k+2. The push commits at k+3. hex*_o and led_o reflect the new entry at k+4 when view_i = 0.
- All outputs are registered. A change on view_i appears on the outputs 1 cycle later.
- Reset (rst_i high at a clock edge) sets:
  - synchronizers to 1 (released button);
  - edge registers, count, wr_ptr and acc to 0;
  - hex1_o = hex2_o = 7'h7F;
  - led_o = 8'h04.
- Reset mid-operation: a strobe edge still inside the synchronizer is discarded. A button held low across reset release produces no pulse.
- Back-to-back pulses (one every cycle) are each pushed. There is no throughput limit.

## Configuration
- ACC_SAT_EN defined: accumulate saturates at 2^DATA_W-1. flag = 1 whenever clamping occurs.
- ACC_SAT_EN undefined: accumulate wraps mod 2^DATA_W. flag = carry out.
- The other modes are identical in both builds.

## Test plan
All scenarios use DATA_W=4 and HIST_DEPTH=4.
- Reset: after reset, hex1_o = hex2_o = 7'h7F, led_o = 8'h04. A strobe held low across reset release leaves count at 0.
- Add with carry: a=9, b=8, mode 0, one strobe, view 0 -> hex1_o = 7'h79 ('1'), hex2_o = 7'h40, led_o = 8'b0000_1001. The outputs are valid exactly 4 clocks after the sampled edge.
- Wrap-around: mode 1, five strobes with (a,b) = (1,0),(2,0),(3,0),(4,0),(5,0) -> count=4, led_o[1]=1. view 0 shows '5' (7'h12). view 3 shows '2' (7'h24). The first result (1) is lost.
- Sub borrow / and zero: a=3, b=5, mode 1 -> res E (7'h06), flag 1. a=5, b=2, mode 2 -> res 0, flag 1.
- Accumulate: a=15 twice from clear:
  - with ACC_SAT_EN -> results F, F, second flag 1;
  - without -> F, E, second flag 1.
- Clear collision: clr and strobe pulses in the same cycle -> count 0, led_o = 8'h04, digits blank. The next accumulate of a=3 yields 3.
